// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state
// encodings, default fetch stride and reset address, and PC alignment.
package fetch_pkg;

    localparam int unsigned PC_STEP_DEFAULT  = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef logic [2:0] fetch_state_t;

    localparam fetch_state_t S_IDLE    = 3'd0;
    localparam fetch_state_t S_REQ     = 3'd1;
    localparam fetch_state_t S_WAIT    = 3'd2;
    localparam fetch_state_t S_FULL    = 3'd3;
    localparam fetch_state_t S_DISCARD = 3'd4;

    // Redirect targets are word aligned; the two low bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding register used when an instruction word
// returns while the decode latch is occupied and stalled.
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    // Occupancy flag: reset/clear empty it, load fills it, drain empties it.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    // Payload capture; contents are meaningful only while valid is set.
    // NOTE: payload registers carry no reset; the valid flag qualifies them, so resetting the data would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (load) begin
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues one request at a time, presents the
// returned word to decode with a one-entry skid, and handles redirects by
// flushing and, when a request is in flight, discarding its response.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_next_pc
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic         transfer;
    logic         load_ack;
    logic         skid_load;
    logic         skid_drain;
    logic         skid_valid;
    logic [31:0]  skid_instr;
    logic [31:0]  skid_pc;

    assign transfer = out_valid && !stall;

    // The request is decoded from state so it is a single-cycle pulse.
    assign imem_req  = (state == S_REQ);
    assign imem_addr = (state == S_REQ) ? pc : 32'h0;

    // Next-state, next-PC and datapath steering; redirect takes priority.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned, which would infer a latch.
        state_nxt  = state;
        pc_nxt     = pc;
        load_ack   = 1'b0;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        if (redirect_valid) begin
            pc_nxt = align_pc(redirect_pc);
            unique case (state)
                S_REQ:     state_nxt = S_DISCARD;
                S_WAIT,
                S_DISCARD: state_nxt = imem_ack ? S_REQ : S_DISCARD;
                default:   state_nxt = S_REQ;
            endcase
        end else begin
            unique case (state)
                S_IDLE: state_nxt = S_REQ;
                S_REQ:  state_nxt = S_WAIT;
                S_WAIT: begin
                    if (imem_ack) begin
                        pc_nxt = pc + STEP;
                        if (out_valid && stall) begin
                            skid_load = 1'b1;
                            state_nxt = S_FULL;
                        end else begin
                            load_ack  = 1'b1;
                            state_nxt = S_REQ;
                        end
                    end
                end
                S_FULL: begin
                    if (transfer) begin
                        skid_drain = 1'b1;
                        state_nxt  = S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (imem_ack) begin
                        state_nxt = S_REQ;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM state and fetch PC registers.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Decode-latch outputs: load from memory, refill from skid, or retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_instr   <= 32'h0;
            out_pc      <= 32'h0;
            out_next_pc <= 32'h0;
        end else if (redirect_valid) begin
            out_valid <= 1'b0;
        end else if (load_ack) begin
            out_valid   <= 1'b1;
            out_instr   <= imem_data;
            out_pc      <= pc;
            out_next_pc <= pc + STEP;
        end else if (skid_drain) begin
            out_valid   <= 1'b1;
            out_instr   <= skid_instr;
            out_pc      <= skid_pc;
            out_next_pc <= skid_pc + STEP;
        end else if (transfer) begin
            out_valid <= 1'b0;
        end
    end

    fetch_skid_buffer u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .drain      (skid_drain),
        .clear      (redirect_valid),
        .load_instr (imem_data),
        .load_pc    (pc),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    // skid_valid mirrors state == S_FULL; kept for observability only.
    logic unused_skid_valid;
    assign unused_skid_valid = skid_valid;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed, table-driven bench for fetch_controller. Each row lists the
// outputs expected at that cycle's falling edge and the inputs then driven
// for the next rising edge. A second instance with RESET_PC = FFFF_FFFC
// shares the stimulus to exercise PC wrap.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid, imem_ack;
    logic [31:0] redirect_pc, imem_data;

    logic        imem_req, out_valid;
    logic [31:0] imem_addr, out_instr, out_pc, out_next_pc;
    logic        w_imem_req, w_out_valid;
    logic [31:0] w_imem_addr, w_out_instr, w_out_pc, w_out_next_pc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_controller dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .out_valid(out_valid), .out_instr(out_instr),
        .out_pc(out_pc), .out_next_pc(out_next_pc)
    );

    fetch_controller #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .out_valid(w_out_valid), .out_instr(w_out_instr),
        .out_pc(w_out_pc), .out_next_pc(w_out_next_pc)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] data;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic        chk;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_next;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic rs, input logic st, input logic rv, input logic [31:0] rpc,
        input logic ack, input logic [31:0] data,
        input logic e_req, input logic [31:0] e_addr, input logic e_valid,
        input logic chk, input logic [31:0] e_instr, input logic [31:0] e_pc,
        input logic [31:0] e_next);
        vec_t v;
        v.rst = rs; v.stall = st; v.rv = rv; v.rpc = rpc; v.ack = ack; v.data = data;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.chk = chk;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_next = e_next;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; stall = v.stall; redirect_valid = v.rv; redirect_pc = v.rpc;
        imem_ack = v.ack; imem_data = v.data;
    endtask

    initial begin
        //            rst st rv rpc            ack data           req addr           vld chk instr          pc             next
        tbl[0]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 1, 32'h0,         32'h0,         32'h0);
        tbl[1]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0);
        tbl[2]  = mk(0, 0, 0, 32'h0,         1, 32'hA000_0000, 0, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0);
        tbl[3]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h4,         1, 1, 32'hA000_0000, 32'h0,         32'h4);
        tbl[4]  = mk(0, 0, 0, 32'h0,         1, 32'hA000_0001, 0, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0);
        tbl[5]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h8,         1, 1, 32'hA000_0001, 32'h4,         32'h8);
        tbl[6]  = mk(0, 1, 0, 32'h0,         1, 32'hA000_0002, 0, 32'h0,         1, 1, 32'hA000_0001, 32'h4,         32'h8);
        tbl[7]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 1, 32'hA000_0001, 32'h4,         32'h8);
        tbl[8]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 1, 32'hA000_0001, 32'h4,         32'h8);
        tbl[9]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 1, 32'hA000_0001, 32'h4,         32'h8);
        tbl[10] = mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 1, 32'hA000_0001, 32'h4,         32'h8);
        tbl[11] = mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 1, 32'hA000_0001, 32'h4,         32'h8);
        tbl[12] = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'hC,         1, 1, 32'hA000_0002, 32'h8,         32'hC);
        tbl[13] = mk(0, 0, 1, 32'h0000_0103, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0);
        tbl[14] = mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0);
        tbl[15] = mk(0, 0, 0, 32'h0,         1, 32'hDEAD_BEEF, 0, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0);
        tbl[16] = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h100,       0, 0, 32'h0,         32'h0,         32'h0);
        tbl[17] = mk(0, 0, 1, 32'h0000_0200, 1, 32'hB000_0000, 0, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0);
        tbl[18] = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h200,       0, 0, 32'h0,         32'h0,         32'h0);
        tbl[19] = mk(0, 0, 0, 32'h0,         1, 32'hC000_0000, 0, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0);
        tbl[20] = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h204,       1, 1, 32'hC000_0000, 32'h200,       32'h204);
        tbl[21] = mk(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0);
        tbl[22] = mk(0, 0, 0, 32'h0,         1, 32'hF000_0000, 0, 32'h0,         0, 1, 32'h0,         32'h0,         32'h0);
        tbl[23] = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0);
        tbl[24] = mk(0, 0, 0, 32'h0,         1, 32'hD000_0000, 0, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0);

        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_data = 32'h0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            check($sformatf("row%0d imem_req", i), {31'h0, imem_req}, {31'h0, tbl[i].e_req});
            check($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].e_addr);
            check($sformatf("row%0d out_valid", i), {31'h0, out_valid}, {31'h0, tbl[i].e_valid});
            if (tbl[i].chk) begin
                check($sformatf("row%0d out_instr", i), out_instr, tbl[i].e_instr);
                check($sformatf("row%0d out_pc", i), out_pc, tbl[i].e_pc);
                check($sformatf("row%0d out_next_pc", i), out_next_pc, tbl[i].e_next);
            end
            if (i == 1) begin
                check("wrap first imem_addr", w_imem_addr, 32'hFFFF_FFFC);
            end
            if (i == 3) begin
                check("wrap second imem_addr", w_imem_addr, 32'h0);
                check("wrap out_pc", w_out_pc, 32'hFFFF_FFFC);
                check("wrap out_next_pc", w_out_next_pc, 32'h0);
            end
            drive(tbl[i]);
        end

        // Redirect during the REQ cycle: the in-flight response must be discarded.
        @(negedge clk);
        check("hs load out_instr", out_instr, 32'hD000_0000);
        check("hs load out_valid", {31'h0, out_valid}, 32'h1);
        check("hs req addr", imem_addr, 32'h4);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0042; imem_ack = 1'b0;
        @(negedge clk);
        check("hs flush out_valid", {31'h0, out_valid}, 32'h0);
        check("hs discard no req", {31'h0, imem_req}, 32'h0);
        redirect_valid = 1'b0;
        @(negedge clk);
        check("hs discard wait no req", {31'h0, imem_req}, 32'h0);
        imem_ack = 1'b1; imem_data = 32'hE000_0000;
        @(negedge clk);
        imem_ack = 1'b0;
        check("hs dropped out_valid", {31'h0, out_valid}, 32'h0);
        check("hs refetch req", {31'h0, imem_req}, 32'h1);
        check("hs refetch addr", imem_addr, 32'h40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter PC_STEP, default 4, byte increment per sequential fetch.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  downstream not accepting; out_* held while high.
REQ-006 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-007 redirect_pc  input  32  redirect target; bits [1:0] ignored and forced to 0.
REQ-008 imem_req  output  1  one-cycle fetch request pulse.
REQ-009 imem_addr  output  32  fetch address; valid when imem_req=1.
REQ-010 imem_ack  input  1  response strobe; never asserted in the same cycle as its request.
REQ-011 imem_data  input  32  instruction word; valid when imem_ack=1.
REQ-012 out_valid  output  1  out_instr/out_pc/out_next_pc valid to decode latch.
REQ-013 out_instr  output  32  fetched instruction.
REQ-014 out_pc  output  32  address of out_instr.
REQ-015 out_next_pc  output  32  out_pc + PC_STEP, modulo 2^32.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, FULL, DISCARD.
- IDLE->REQ unconditionally.
- REQ: imem_req=1, imem_addr=pc; ->WAIT.
- WAIT: on ack ->REQ, or ->FULL if the skid entry is filled.
REQ-017 Transfer occurs when out_valid=1 and stall=0; out_* are replaced or cleared on the following edge.
REQ-018 On an accepted ack, imem_data and the request address are loaded into out_*, out_valid=1, and pc<=pc+PC_STEP.
REQ-019 Ack arriving while out_valid=1 and stall=1 writes a one-entry skid buffer; state->FULL; no new request while FULL.
REQ-020 FULL: on transfer, the skid entry moves to out_*, skid is emptied, state->REQ.
REQ-021 At most one request is outstanding at any time.
REQ-022 pc arithmetic wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
REQ-023 redirect_valid has highest priority:
- pc<=redirect_pc & ~3.
- out_valid and skid are cleared in the same edge.
REQ-024 Redirect when no request is outstanding (IDLE, REQ-not-yet-issued, FULL): ->REQ next cycle.
REQ-025 Redirect in REQ cycle (request issued) or WAIT without ack: ->DISCARD.
REQ-026 DISCARD: the next ack is dropped (no out_* update, no pc increment); then ->REQ.
REQ-027 Redirect coinciding with ack in WAIT: ack dropped, ->REQ (no DISCARD).
REQ-028 Redirect coinciding with ack in DISCARD: ack dropped, pc updated, ->REQ.
REQ-029 stall has no effect on imem_req except via FULL; stall and redirect together: redirect wins.
REQ-030 Minimum latency: rst low at edge N -> imem_req in cycle N+1 -> earliest ack N+2 -> out_valid N+3.

Reset
REQ-031 On rst=1 at an edge: state=IDLE, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, out_next_pc=0, skid empty, imem_req=0, imem_addr=0.
REQ-032 Reset mid-operation abandons any outstanding request; the first ack after reset while in IDLE/REQ is dropped.

Structure
REQ-033 Shared package fetch_pkg holds the FSM state enum, PC_STEP and default RESET_PC.
REQ-034 One sub-module, fetch_skid_buffer: 1-entry {instr, pc} register with load/drain/clear.
REQ-035 All outputs are registered except imem_req and imem_addr, which are decoded from state and pc.

Verification
REQ-036 Reset, then ack 1 cycle after each req, stall=0 -> imem_addr 0,4,8,...; out_pc tracks; out_valid first at cycle 3.
REQ-037 Stall held 5 cycles while out_valid, ack arrives -> FULL, no imem_req; stall drops -> skid instr appears next cycle, out_pc+4.
REQ-038 Redirect to 32'h100 while WAIT, ack 2 cycles later -> that ack dropped; next imem_addr=32'h100; out_valid=0 in between.
REQ-039 Redirect and ack in the same cycle -> ack dropped, next req at target, no DISCARD entered.
REQ-040 RESET_PC=32'hFFFF_FFFC -> second imem_addr=0; rst asserted mid-WAIT -> all outputs 0, stray ack ignored.
